csr_spmv_sched: RTL and testbench
=================================

Name: csr_spmv_sched

Overview:
- Sequencer for the two-port sparse matrix-vector (CSR) fetch datapath.
- Walks the row-pointer, column-index, matrix-value and vector-value arrays for a programmed number of rows.
- Shares read port 2 between matrix-value and vector-value fetches.
- Streams (matrix value, vector value) pairs with row tags to a downstream MAC over a valid/ready handshake.

Parameters:
- AW, 32, address width of both read ports and all base registers.
- DW, 32, data width of both read ports and of the output values.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a traversal; ignored while busy=1.
- row_base  in  AW  base address of the row-pointer array (num_rows+1 entries).
- col_base  in  AW  base address of the column-index array.
- mat_base  in  AW  base address of the matrix-value array.
- v_base  in  AW  base address of the dense vector.
- num_rows  in  32  number of rows to process; 0 is legal.
- csize  in  32  number of vector elements (column count).
- addr1  out  AW  port-1 read address (row pointers, column indices).
- rd1  out  1  port-1 read enable.
- dataIn1  in  DW  port-1 read data; combinational, valid in the same cycle as addr1.
- addr2  out  AW  port-2 read address (matrix values, vector values).
- rd2  out  1  port-2 read enable.
- dataIn2  in  DW  port-2 read data; combinational, same cycle as addr2.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_mval  out  DW  matrix value.
- out_vval  out  DW  vector value.
- out_row  out  32  row index of the beat.
- out_last  out  1  last beat of the row.
- out_empty  out  1  beat marks an empty row; values are 0 and out_last=1.
- busy  out  1  traversal in progress.
- done  out  1  one-cycle pulse after the final row's last beat is accepted.
- err  out  1  sticky error flag (see Optional Feature); 0 when the feature is compiled out.

Behaviour:
- Reset (async, Rst=1) clears all state: state=IDLE; all outputs 0; internal row, k and end registers 0. Reset mid-traversal abandons it immediately; no done pulse is produced.
- Base, num_rows and csize inputs are sampled on the start cycle and held internally.
- addr/rd outputs are registered. The data returned during a state is captured at the clock edge ending that state.
- IDLE: busy=0. On start: if num_rows==0, go to FIN; otherwise r=0 and go to RP0.
- RP0: addr1=row_base, rd1=1; capture k=dataIn1. Go to RP1.
- RP1: addr1=row_base+r+1, rd1=1; capture end=dataIn1. If k==end, go to OUT with the empty beat (out_empty=1, out_last=1); otherwise go to FET.
- FET: addr1=col_base+k, addr2=mat_base+k, rd1=rd2=1; capture col=dataIn1 and mval=dataIn2. Go to VEC.
- VEC: addr2=v_base+col, rd2=1; capture vval=dataIn2. Go to OUT.
- OUT: out_valid=1 with registered outputs held stable until out_ready.
  - On accept with a non-last beat: k=k+1, go to FET.
  - On accept with the last beat (k+1==end, or an empty beat): if r+1==num_rows, go to FIN; otherwise r=r+1, k=end, go to RP1. RP0 is not re-entered; the previous end is reused.
- FIN: done=1 for one cycle, then IDLE.
- Port-2 arbitration is fixed by state: FET gives it to the matrix value, VEC to the vector value. No conflict is possible.
- Throughput with out_ready held high: 3 cycles per nonzero, +1 cycle per row (RP1), +1 cycle per traversal (RP0).
- Arithmetic: all address additions are modulo 2^AW and wrap silently. If end<k (malformed pointers), the row is treated as empty.
- out_ready is ignored outside OUT. A start during busy has no effect.

Optional Feature:
- Macro: CSR_COL_CHECK_EN.
- When defined: in FET, if dataIn1 >= csize, the nonzero is skipped. VEC is not entered. err is set and stays set until Rst. The beat is replaced by a zero-value beat (out_mval=0, out_vval=0) so row framing and out_last stay correct.
- When undefined: no check is made, err is tied to 0, and any column index is used directly.

Test Plan:
- Reset: hold Rst=1 mid-run, then release -> all outputs 0, state IDLE, no done pulse.
- 16x16 matrix, row_base=20220 (pointers 0,7,12,...), col_base=1920, mat_base=90, v_base=2, out_ready=1 -> row 0 emits 7 beats; beat 0 is mval=66, vval=96 (col 2, addr 4); beat 6 has out_last=1; done pulses after row 15 ends with beat k=97.
- Backpressure: out_ready=0 for 5 cycles on beat 0 -> outputs stable (66, 96, row 0), no address advance; resumes on ready.
- Empty row: row pointers 0,0,3 with num_rows=2 -> one beat out_empty=1, out_last=1, row 0, then 3 beats for row 1.
- num_rows=0 -> done one cycle after start; rd1 and rd2 never asserted.
- CSR_COL_CHECK_EN with csize=8 on row 0 -> err=1; the beats for cols 8, 9, 10, 12 and 15 are zero-valued; 7 beats still emitted.

Source files
------------

// File: rtl/csr_spmv_sched_if.sv
// csr_spmv_sched_if: bundles the two read ports and the beat stream of the
// CSR SpMV fetch sequencer. The sequencer uses the master side; memories and
// the downstream MAC sit on the slave side.
interface csr_spmv_sched_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Read port 1: row pointers and column indices
  logic [AW-1:0] addr1;
  logic          rd1;
  logic [DW-1:0] dataIn1;

  // Read port 2: matrix values and vector values
  logic [AW-1:0] addr2;
  logic          rd2;
  logic [DW-1:0] dataIn2;

  // Beat stream towards the MAC
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mval;
  logic [DW-1:0] out_vval;
  logic [31:0]   out_row;
  logic          out_last;
  logic          out_empty;

  modport master (
    output addr1, rd1, addr2, rd2,
    input  dataIn1, dataIn2,
    output out_valid, out_mval, out_vval, out_row, out_last, out_empty,
    input  out_ready
  );

  modport slave (
    input  addr1, rd1, addr2, rd2,
    output dataIn1, dataIn2,
    input  out_valid, out_mval, out_vval, out_row, out_last, out_empty,
    output out_ready
  );
endinterface

// File: rtl/csr_spmv_sched.sv
// csr_spmv_sched: walks a CSR matrix (row pointers, column indices, values)
// and the dense vector, and streams (matrix value, vector value) pairs tagged
// with their row to a MAC. Port 2 is time-shared: FET reads the matrix value,
// VEC reads the vector value.
//
// Optional build macro: CSR_COL_CHECK_EN
//   defined   -> column indices >= csize are skipped, replaced by a zero beat,
//                and the sticky err flag is raised.
//   undefined -> no column check, err is tied to 0.
module csr_spmv_sched #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [AW-1:0]     row_base,
  input  logic [AW-1:0]     col_base,
  input  logic [AW-1:0]     mat_base,
  input  logic [AW-1:0]     v_base,
  input  logic [31:0]       num_rows,
  input  logic [31:0]       csize,
  csr_spmv_sched_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RP0,
    S_RP1,
    S_FET,
    S_VEC,
    S_OUT,
    S_FIN
  } state_t;

  state_t        state;

  // Traversal configuration, frozen on the start cycle
  logic [AW-1:0] row_base_q;
  logic [AW-1:0] col_base_q;
  logic [AW-1:0] mat_base_q;
  logic [AW-1:0] v_base_q;
  logic [31:0]   num_rows_q;

  // Walk position: current row, current nonzero, end of current row
  logic [31:0]   r_q;
  logic [DW-1:0] k_q;
  logic [DW-1:0] end_q;
  logic [DW-1:0] mval_q;

  logic [DW-1:0] k_inc;
  logic [31:0]   r_inc;
  logic          col_bad;

  assign k_inc = k_q + DW'(1);
  assign r_inc = r_q + 32'd1;

`ifdef CSR_COL_CHECK_EN
  // Compare the fetched column index against csize at a common width so
  // neither side is truncated.
  localparam int CW = (DW > 32) ? DW : 32;
  logic [CW-1:0] col_ext;
  logic [CW-1:0] csize_ext;
  logic [31:0]   csize_q;

  assign col_ext   = CW'(bus.dataIn1);
  assign csize_ext = CW'(csize_q);
  assign col_bad   = (col_ext >= csize_ext);

  // Hold csize for the whole traversal, like the other configuration inputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      csize_q <= '0;
    end else if (state == S_IDLE && start) begin
      csize_q <= csize;
    end
  end

  // Sticky error: any out-of-range column seen since reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err <= 1'b0;
    end else if (state == S_FET && col_bad) begin
      err <= 1'b1;
    end
  end
`else
  // csize only matters when the column check is built in
  logic unused_csize;
  assign unused_csize = ^csize;
  assign col_bad      = 1'b0;
  assign err          = 1'b0;
`endif

  // Sequencer FSM: state, walk registers and all registered outputs
  // NOTE: asynchronous active-high reset; every flop here is cleared by Rst
  // without waiting for a clock edge, so a reset mid-traversal aborts at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= S_IDLE;
      row_base_q    <= '0;
      col_base_q    <= '0;
      mat_base_q    <= '0;
      v_base_q      <= '0;
      num_rows_q    <= '0;
      r_q           <= '0;
      k_q           <= '0;
      end_q         <= '0;
      mval_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.addr1     <= '0;
      bus.rd1       <= 1'b0;
      bus.addr2     <= '0;
      bus.rd2       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_mval  <= '0;
      bus.out_vval  <= '0;
      bus.out_row   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_empty <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; done defaults low here and
      // is raised only on the transition into FIN, giving a one-cycle pulse.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            row_base_q <= row_base;
            col_base_q <= col_base;
            mat_base_q <= mat_base;
            v_base_q   <= v_base;
            num_rows_q <= num_rows;
            r_q        <= '0;
            busy       <= 1'b1;
            if (num_rows == 32'd0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              // Address is registered, so the first pointer read must be
              // set up from the live input on the start cycle.
              bus.addr1 <= row_base;
              bus.rd1   <= 1'b1;
              state     <= S_RP0;
            end
          end
        end

        S_RP0: begin
          k_q       <= bus.dataIn1;
          bus.addr1 <= row_base_q + AW'(r_q) + AW'(1);
          bus.rd1   <= 1'b1;
          state     <= S_RP1;
        end

        S_RP1: begin
          end_q <= bus.dataIn1;
          if (bus.dataIn1 <= k_q) begin
            // k==end is an empty row; end<k is malformed and handled the same
            bus.rd1       <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_mval  <= '0;
            bus.out_vval  <= '0;
            bus.out_row   <= r_q;
            bus.out_last  <= 1'b1;
            bus.out_empty <= 1'b1;
            state         <= S_OUT;
          end else begin
            bus.addr1 <= col_base_q + AW'(k_q);
            bus.addr2 <= mat_base_q + AW'(k_q);
            bus.rd1   <= 1'b1;
            bus.rd2   <= 1'b1;
            state     <= S_FET;
          end
        end

        S_FET: begin
          mval_q  <= bus.dataIn2;
          bus.rd1 <= 1'b0;
          if (col_bad) begin
            // Out-of-range column: no vector read, emit a zero beat that
            // keeps the row framing intact.
            bus.rd2       <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_mval  <= '0;
            bus.out_vval  <= '0;
            bus.out_row   <= r_q;
            bus.out_last  <= (k_inc == end_q);
            bus.out_empty <= 1'b0;
            state         <= S_OUT;
          end else begin
            bus.addr2 <= v_base_q + AW'(bus.dataIn1);
            bus.rd2   <= 1'b1;
            state     <= S_VEC;
          end
        end

        S_VEC: begin
          bus.rd2       <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_mval  <= mval_q;
          bus.out_vval  <= bus.dataIn2;
          bus.out_row   <= r_q;
          bus.out_last  <= (k_inc == end_q);
          bus.out_empty <= 1'b0;
          state         <= S_OUT;
        end

        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (!bus.out_last) begin
              // Next nonzero in the same row
              k_q       <= k_inc;
              bus.addr1 <= col_base_q + AW'(k_inc);
              bus.addr2 <= mat_base_q + AW'(k_inc);
              bus.rd1   <= 1'b1;
              bus.rd2   <= 1'b1;
              state     <= S_FET;
            end else if (r_inc == num_rows_q) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              // The previous row's end pointer is the next row's start, so
              // only the new end pointer is read.
              r_q       <= r_inc;
              k_q       <= end_q;
              bus.addr1 <= row_base_q + AW'(r_inc) + AW'(1);
              bus.rd1   <= 1'b1;
              state     <= S_RP1;
            end
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_spmv_sched.sv
// tb_csr_spmv_sched: directed bench for csr_spmv_sched. A word-addressed
// memory model answers both read ports combinationally; expected beats are
// derived from the memory image by walking the CSR arrays independently.
module tb_csr_spmv_sched;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef CSR_COL_CHECK_EN
  localparam bit COLCHK = 1'b1;
`else
  localparam bit COLCHK = 1'b0;
`endif

  localparam logic [31:0] ROW_BASE   = 32'd20220;
  localparam logic [31:0] EROW_BASE  = 32'd21000;
  localparam logic [31:0] COL_BASE   = 32'd1920;
  localparam logic [31:0] MAT_BASE   = 32'd90;
  localparam logic [31:0] V_BASE     = 32'd2;

  typedef struct packed {
    logic [31:0] mval;
    logic [31:0] vval;
    logic [31:0] row;
    logic        last;
    logic        empty;
  } beat_t;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [AW-1:0] row_base;
  logic [AW-1:0] col_base;
  logic [AW-1:0] mat_base;
  logic [AW-1:0] v_base;
  logic [31:0]   num_rows;
  logic [31:0]   csize;
  logic          busy;
  logic          done;
  logic          err;

  logic [31:0]   mem [0:32767];

  beat_t         exp_q[$];
  beat_t         log_q[$];

  int            checks = 0;
  int            errors = 0;

  csr_spmv_sched_if #(.AW(AW), .DW(DW)) bus ();

  csr_spmv_sched #(.AW(AW), .DW(DW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .row_base (row_base),
    .col_base (col_base),
    .mat_base (mat_base),
    .v_base   (v_base),
    .num_rows (num_rows),
    .csize    (csize),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign bus.dataIn1 = mem[bus.addr1[14:0]];
  assign bus.dataIn2 = mem[bus.addr2[14:0]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem[a[14:0]];
  endfunction

  // Expected beat list from a straightforward CSR walk of the memory image
  task automatic build_model(input logic [31:0] rb, input logic [31:0] nr,
                             input logic [31:0] cs);
    beat_t       b;
    logic [31:0] k, e, col;
    exp_q.delete();
    for (int r = 0; r < int'(nr); r++) begin
      k = rdm(rb + 32'(r));
      e = rdm(rb + 32'(r) + 32'd1);
      if (e <= k) begin
        b = '0;
        b.row   = 32'(r);
        b.last  = 1'b1;
        b.empty = 1'b1;
        exp_q.push_back(b);
      end else begin
        for (logic [31:0] kk = k; kk < e; kk++) begin
          col = rdm(COL_BASE + kk);
          b = '0;
          b.row  = 32'(r);
          b.last = (kk == e - 32'd1);
          if (!(COLCHK && col >= cs)) begin
            b.mval = rdm(MAT_BASE + kk);
            b.vval = rdm(V_BASE + col);
          end
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Score accepted beats until done or the budget expires; reports the
  // number of cycles from the call until done was seen.
  task automatic collect(input int budget, output int cycles);
    bit    got_done = 1'b0;
    int    extras   = 0;
    beat_t b;
    cycles = 0;
    log_q.delete();
    while (!got_done && cycles < budget) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          extras++;
        end else begin
          b = exp_q.pop_front();
          check("beat_mval",  bus.out_mval,        b.mval);
          check("beat_vval",  bus.out_vval,        b.vval);
          check("beat_row",   bus.out_row,         b.row);
          check("beat_last",  32'(bus.out_last),   32'(b.last));
          check("beat_empty", 32'(bus.out_empty),  32'(b.empty));
          b.mval  = bus.out_mval;
          b.vval  = bus.out_vval;
          b.row   = bus.out_row;
          b.last  = bus.out_last;
          b.empty = bus.out_empty;
          log_q.push_back(b);
        end
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        @(negedge Clk);
        cycles++;
      end
    end
    check("done_seen",       32'(got_done),     32'd1);
    check("beats_remaining", 32'(exp_q.size()), 32'd0);
    check("extra_beats",     32'(extras),       32'd0);
  endtask

  task automatic config_main(input logic [31:0] nr, input logic [31:0] cs);
    row_base = ROW_BASE;
    col_base = COL_BASE;
    mat_base = MAT_BASE;
    v_base   = V_BASE;
    num_rows = nr;
    csize    = cs;
  endtask

  initial begin
    int          cyc;
    int          ptr;
    int          n;
    int          row0_cols [7] = '{2, 5, 8, 9, 10, 12, 15};
    logic [31:0] a1, a2;
    bit          bp_valid;
    bit          saw_done;

    // Memory image: 16x16 matrix, 98 nonzeros, row pointers 0,7,12,18,...
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    ptr = 0;
    for (int r = 0; r < 16; r++) begin
      mem[ROW_BASE[14:0] + 15'(r)] = 32'(ptr);
      n = (r == 0) ? 7 : (r == 1) ? 5 : (r < 14) ? 6 : 7;
      for (int j = 0; j < n; j++) begin
        mem[COL_BASE[14:0] + 15'(ptr)] = (r == 0) ? 32'(row0_cols[j]) : 32'((r + 3 * j) % 16);
        mem[MAT_BASE[14:0] + 15'(ptr)] = 32'(66 + 3 * ptr);
        ptr++;
      end
    end
    mem[ROW_BASE[14:0] + 15'd16] = 32'(ptr);
    for (int c = 0; c < 16; c++) mem[V_BASE[14:0] + 15'(c)] = 32'(86 + 5 * c);
    // Empty-row image: pointers 0,0,3
    mem[EROW_BASE[14:0]]         = 32'd0;
    mem[EROW_BASE[14:0] + 15'd1] = 32'd0;
    mem[EROW_BASE[14:0] + 15'd2] = 32'd3;

    // Reset state
    Rst   = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    config_main(32'd0, 32'd16);
    repeat (2) @(negedge Clk);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_err",       32'(err),           32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd1",       32'(bus.rd1),       32'd0);
    check("rst_rd2",       32'(bus.rd2),       32'd0);
    check("rst_addr1",     bus.addr1,          32'd0);
    check("rst_out_row",   bus.out_row,        32'd0);
    Rst = 1'b0;

    // Full 16-row traversal with out_ready held high
    bus.out_ready = 1'b1;
    config_main(32'd16, 32'd16);
    build_model(ROW_BASE, 32'd16, 32'd16);
    pulse_start();
    check("main_busy", 32'(busy), 32'd1);
    collect(2000, cyc);
    check("main_cycles",     32'(cyc),            32'd311);
    check("main_beat_count", 32'(log_q.size()),   32'd98);
    check("main_b0_mval",    log_q[0].mval,       32'd66);
    check("main_b0_vval",    log_q[0].vval,       32'd96);
    check("main_b5_last",    32'(log_q[5].last),  32'd0);
    check("main_b6_last",    32'(log_q[6].last),  32'd1);
    check("main_b7_row",     log_q[7].row,        32'd1);
    check("main_b97_row",    log_q[97].row,       32'd15);
    check("main_b97_last",   32'(log_q[97].last), 32'd1);
    check("main_b97_mval",   log_q[97].mval,      32'd357);
    @(negedge Clk);
    check("main_done_pulse", 32'(done), 32'd0);
    check("main_idle_busy",  32'(busy), 32'd0);
    check("main_err",        32'(err),  32'd0);

    // Backpressure on beat 0
    bus.out_ready = 1'b0;
    build_model(ROW_BASE, 32'd16, 32'd16);
    pulse_start();
    bp_valid = 1'b0;
    for (int i = 0; i < 20 && !bp_valid; i++) begin
      if (bus.out_valid) bp_valid = 1'b1;
      else @(negedge Clk);
    end
    check("bp_valid_reached", 32'(bp_valid), 32'd1);
    a1 = bus.addr1;
    a2 = bus.addr2;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_mval",  bus.out_mval,       32'd66);
      check("bp_vval",  bus.out_vval,       32'd96);
      check("bp_row",   bus.out_row,        32'd0);
      check("bp_addr1", bus.addr1,          a1);
      check("bp_addr2", bus.addr2,          a2);
    end
    bus.out_ready = 1'b1;
    collect(2000, cyc);
    check("bp_beat_count", 32'(log_q.size()), 32'd98);
    @(negedge Clk);

    // num_rows == 0: done on the cycle after start, no reads
    config_main(32'd0, 32'd16);
    pulse_start();
    check("nr0_done", 32'(done),    32'd1);
    check("nr0_rd1",  32'(bus.rd1), 32'd0);
    check("nr0_rd2",  32'(bus.rd2), 32'd0);
    @(negedge Clk);
    check("nr0_done_pulse", 32'(done),    32'd0);
    check("nr0_rd1_after",  32'(bus.rd1), 32'd0);
    check("nr0_rd2_after",  32'(bus.rd2), 32'd0);
    check("nr0_busy_after", 32'(busy),    32'd0);

    // Column check with csize=8 on row 0
    config_main(32'd1, 32'd8);
    build_model(ROW_BASE, 32'd1, 32'd8);
    pulse_start();
    collect(200, cyc);
    check("cc_beat_count", 32'(log_q.size()),  32'd7);
    check("cc_b0_mval",    log_q[0].mval,      32'd66);
    check("cc_b1_mval",    log_q[1].mval,      32'd69);
    check("cc_b2_mval",    log_q[2].mval,      COLCHK ? 32'd0 : 32'd72);
    check("cc_b6_vval",    log_q[6].vval,      COLCHK ? 32'd0 : 32'd161);
    check("cc_b6_last",    32'(log_q[6].last), 32'd1);
    @(negedge Clk);
    check("cc_err",        32'(err),           32'(COLCHK));

    // Reset mid-traversal abandons the walk, no done pulse
    config_main(32'd16, 32'd16);
    pulse_start();
    repeat (30) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),          32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rd1",   32'(bus.rd1),       32'd0);
    check("mid_rst_rd2",   32'(bus.rd2),       32'd0);
    check("mid_rst_addr2", bus.addr2,          32'd0);
    check("mid_rst_err",   32'(err),           32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (done || busy || bus.out_valid) saw_done = 1'b1;
    end
    check("mid_rst_quiet", 32'(saw_done), 32'd0);

    // Empty row followed by a 3-nonzero row
    row_base = EROW_BASE;
    num_rows = 32'd2;
    build_model(EROW_BASE, 32'd2, 32'd16);
    pulse_start();
    collect(200, cyc);
    check("er_cycles",     32'(cyc),            32'd13);
    check("er_beat_count", 32'(log_q.size()),   32'd4);
    check("er_b0_empty",   32'(log_q[0].empty), 32'd1);
    check("er_b0_last",    32'(log_q[0].last),  32'd1);
    check("er_b0_row",     log_q[0].row,        32'd0);
    check("er_b0_mval",    log_q[0].mval,       32'd0);
    check("er_b1_mval",    log_q[1].mval,       32'd66);
    check("er_b1_row",     log_q[1].row,        32'd1);
    check("er_b3_last",    32'(log_q[3].last),  32'd1);
    check("er_b3_row",     log_q[3].row,        32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
